// File: rtl/display_framebuffer.sv
// -----------------------------------------------------------------------------
// display_framebuffer
//
// Double-buffered pixel store for a segmented LED-style panel. The display
// driver reads the front bank, and the writer fills the back bank. A commit
// swaps the two banks at the next frame boundary.
//
// Parameters
//   segments : vertically stacked panel segments read in parallel
//   rows     : addressable rows per segment
//   columns  : pixels per row
//   bitwidth : bits per colour channel
//
// Ports
//   clk, rst       : system clock, asynchronous active-high reset
//   row, column    : read address, applied to every segment at once
//   pixel          : registered read data, valid one cycle after the address.
//                    Segment s, channel c (0=R,1=G,2=B) is at bit offset
//                    bitwidth*(3*s+c).
//   frame_complete : one-cycle pulse from the driver at the end of a frame
//   wr_valid/ready : write handshake into the back bank
//   wr_segment, wr_row, wr_column, wr_pixel : write address and data
//   wr_commit      : request a front/back swap at the next frame_complete
//   wr_clear       : request that the whole back bank be zeroed
//   front          : index of the bank being displayed
//   swap_pending   : a commit is waiting for frame_complete
// -----------------------------------------------------------------------------
module display_framebuffer #(
  parameter int segments = 1,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8,
  localparam int RW    = (rows > 1) ? $clog2(rows) : 1,
  localparam int CW    = (columns > 1) ? $clog2(columns) : 1,
  localparam int SW    = (segments > 1) ? $clog2(segments) : 1,
  localparam int PW    = 3 * bitwidth,
  localparam int DEPTH = rows * columns,
  localparam int AW    = $clog2(2 * DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RW-1:0]            row,
  input  logic [CW-1:0]            column,
  output logic [PW*segments-1:0]   pixel,
  input  logic                     frame_complete,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [SW-1:0]            wr_segment,
  input  logic [RW-1:0]            wr_row,
  input  logic [CW-1:0]            wr_column,
  input  logic [PW-1:0]            wr_pixel,
  input  logic                     wr_commit,
  input  logic                     wr_clear,
  output logic                     front,
  output logic                     swap_pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            front_r;
  logic            swap_pending_r;
  logic            wr_ready_r;
  logic [AW-1:0]   clr_cnt_r;
  logic            clr_last_s;
  logic            clearing_s;
  logic            accept_s;
  logic [AW-1:0]   front_base_s;
  logic [AW-1:0]   back_base_s;
  logic [AW-1:0]   rd_addr_s;
  logic [AW-1:0]   wr_addr_s;
  logic [AW-1:0]   clr_addr_s;

  assign front        = front_r;
  assign swap_pending = swap_pending_r;
  assign wr_ready     = wr_ready_r;

  // Both banks live in one array per segment; the bank index selects the upper
  // half, so the read side (front) and write side (back) never overlap.
  always_comb begin
    front_base_s = {AW{1'b0}};
    back_base_s  = {AW{1'b0}};
    if (front_r) begin
      front_base_s = AW'(DEPTH);
      back_base_s  = {AW{1'b0}};
    end else begin
      front_base_s = {AW{1'b0}};
      back_base_s  = AW'(DEPTH);
    end
  end

  assign rd_addr_s  = front_base_s + AW'(row) * AW'(columns) + AW'(column);
  assign wr_addr_s  = back_base_s + AW'(wr_row) * AW'(columns) + AW'(wr_column);
  assign clr_addr_s = back_base_s + clr_cnt_r;
  assign clr_last_s = (clr_cnt_r == AW'(DEPTH - 1));
  assign clearing_s = (state_r == CLEAR);
  assign accept_s   = wr_valid && wr_ready_r;

  // Next-state logic. A commit wins over a clear raised in the same cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (wr_commit) begin
          state_s = PENDING;
        end else if (wr_clear) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        if (clr_last_s) begin
          state_s = IDLE;
        end else begin
          state_s = CLEAR;
        end
      end
      PENDING: begin
        if (frame_complete) begin
          state_s = IDLE;
        end else begin
          state_s = PENDING;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, bank select, handshake flags and clear address counter.
  // wr_ready/swap_pending are registered from the next state, so they line
  // up with state_r after every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      front_r        <= 1'b0;
      swap_pending_r <= 1'b0;
      wr_ready_r     <= 1'b0;
      clr_cnt_r      <= {AW{1'b0}};
    end else begin
      state_r        <= state_s;
      wr_ready_r     <= (state_s == IDLE);
      swap_pending_r <= (state_s == PENDING);
      if ((state_r == PENDING) && frame_complete) begin
        front_r <= ~front_r;
      end else begin
        front_r <= front_r;
      end
      if (clearing_s && !clr_last_s) begin
        clr_cnt_r <= clr_cnt_r + AW'(1);
      end else begin
        clr_cnt_r <= {AW{1'b0}};
      end
    end
  end

  for (genvar s = 0; s < segments; s++) begin : g_seg
    logic [PW-1:0] mem [2*DEPTH];
    logic          we_s;
    logic [AW-1:0] wa_s;
    logic [PW-1:0] wd_s;
    logic [PW-1:0] pix_r;

    // Write port mux: clearing zeroes every segment at once; otherwise only
    // the addressed segment takes an accepted write.
    always_comb begin
      we_s = 1'b0;
      wa_s = wr_addr_s;
      wd_s = wr_pixel;
      if (clearing_s) begin
        we_s = 1'b1;
        wa_s = clr_addr_s;
        wd_s = {PW{1'b0}};
      end else begin
        we_s = accept_s && (wr_segment == SW'(s));
        wa_s = wr_addr_s;
        wd_s = wr_pixel;
      end
    end

    // RAM write port (contents are never reset).
    always_ff @(posedge clk) begin
      if (we_s) begin
        mem[wa_s] <= wd_s;
      end
    end

    // Registered read from the front bank.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pix_r <= {PW{1'b0}};
      end else begin
        pix_r <= mem[rd_addr_s];
      end
    end

    assign pixel[PW*s +: PW] = pix_r;
  end

endmodule

// File: doc/display_framebuffer.md
DISPLAY_FRAMEBUFFER -- requirements
Module: display_framebuffer

Interface
REQ-001 SHALL take parameter segments, default 1: number of vertically stacked panel segments read in parallel.
REQ-002 SHALL take parameter rows, default 8: addressable rows per segment.
REQ-003 SHALL take parameter columns, default 32: pixels per row.
REQ-004 SHALL take parameter bitwidth, default 8: bits per colour channel.
REQ-005 SHALL have one clock; reset is asynchronous and active-high. Ports: clk in 1, system clock; rst in 1, asynchronous active-high reset.
REQ-006 SHALL have row, input, clog2(rows) bits: read row address.
REQ-007 SHALL have column, input, clog2(columns) bits: read column address.
REQ-008 SHALL have pixel, output, 3*bitwidth*segments bits: per segment s, channel c (0=R, 1=G, 2=B) at bit offset bitwidth*(3*s+c).
REQ-009 SHALL have frame_complete, input, 1 bit: single-cycle pulse from the display driver marking the end of a frame.
REQ-010 SHALL have wr_valid in 1 and wr_ready out 1: write handshake.
REQ-011 SHALL have wr_segment in max(1,clog2(segments)), wr_row in clog2(rows), wr_column in clog2(columns), wr_pixel in 3*bitwidth: write address and data, same channel packing as pixel.
REQ-012 SHALL have wr_commit in 1: request to swap back buffer to front at the next frame boundary.
REQ-013 SHALL have wr_clear in 1: request to zero the whole back buffer.
REQ-014 SHALL have front out 1: index of the bank being displayed; swap_pending out 1: commit awaiting frame_complete.

Function
REQ-015 SHALL hold two banks, each segments*rows*columns words of 3*bitwidth, mapped to inferable block RAM (contents not reset).
REQ-016 SHALL read bank front at (row, column) for all segments; pixel SHALL be registered, valid exactly 1 cycle after the address is presented.
REQ-017 SHALL write only to bank ~front; a write occurs on a clk edge where wr_valid && wr_ready.
REQ-018 SHALL implement FSM states IDLE, CLEAR, PENDING.
REQ-019 IDLE: wr_ready=1; wr_commit -> PENDING; else wr_clear -> CLEAR; wr_commit and wr_clear together -> PENDING, clear dropped.
REQ-020 A write accepted in the same cycle as wr_commit or wr_clear SHALL be completed before the state takes effect.
REQ-021 CLEAR: wr_ready=0; writes 0 to one address of the back bank per cycle (all segments in parallel), rows*columns cycles total, address counter row-major, then -> IDLE.
REQ-022 PENDING: wr_ready=0, swap_pending=1; on frame_complete toggle front and -> IDLE; new front visible on pixel for reads addressed the cycle after the toggle.
REQ-023 frame_complete in IDLE or CLEAR SHALL have no effect; wr_commit/wr_clear outside IDLE SHALL be ignored.
REQ-024 Read-port behaviour SHALL be unaffected by any write-side activity (banks disjoint).
REQ-025 After a swap the new back bank SHALL hold the previously displayed frame unchanged (no copy).

Reset
REQ-026 On rst: state=IDLE, front=0, swap_pending=0, wr_ready=0 while rst asserted then 1, pixel=0, clear counter=0.
REQ-027 rst asserted mid-CLEAR or mid-PENDING SHALL abort the operation; RAM contents are undefined afterwards.

Verification
REQ-028 Write (seg0,r2,c5)=0x112233 to back bank, commit, pulse frame_complete, read r2 c5 -> front=1, pixel=0x112233 one cycle after address.
REQ-029 Commit with no frame_complete for 100 cycles -> swap_pending=1, wr_ready=0, front unchanged, wr_valid ignored.
REQ-030 wr_clear with rows=8, columns=32 -> wr_ready low exactly 256 cycles, then commit+frame_complete -> all reads return 0.
REQ-031 wr_commit and wr_clear same cycle with accepted write -> write stored, state PENDING, no clear.
REQ-032 rst pulse during CLEAR at cycle 10 -> front=0, swap_pending=0, wr_ready=1 one cycle after release.
REQ-033 frame_complete while IDLE -> front unchanged; continuous reads across a swap show old data up to the swap edge, new data after.
